// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-stage instruction in, forwarding/stall controls out, for hazard_fwd_ctrl.
interface hazard_fwd_ctrl_if;
  logic [19:0] ins;
  logic        ins_valid;
  logic [1:0]  mux_sel_a;
  logic [1:0]  mux_sel_b;
  logic        imm_sel;
  logic        stall;
  logic [4:0]  RW_dm;
  logic [4:0]  RW_wb;
  logic        wr_en_wb;
  logic [7:0]  stall_cnt;

  modport master (
    output ins, ins_valid,
    input  mux_sel_a, mux_sel_b, imm_sel, stall, RW_dm, RW_wb, wr_en_wb, stall_cnt
  );

  modport slave (
    input  ins, ins_valid,
    output mux_sel_a, mux_sel_b, imm_sel, stall, RW_dm, RW_wb, wr_en_wb, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Tracks EX/DM/WB destination registers and derives operand forwarding selects,
// immediate select and load-use stalls for the instruction currently in decode.
module hazard_fwd_ctrl (
  input  logic              clk,
  input  logic              reset,
  hazard_fwd_ctrl_if.slave  bus
);

  localparam logic [4:0] OP_LD  = 5'h08;
  localparam logic [4:0] OP_ST  = 5'h09;
  localparam logic [4:0] OP_NOP = 5'h1F;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t     r_ex, r_dm, r_wb;
  logic [7:0] r_stall_cnt;

  logic [4:0] w_opcode, w_rd, w_rs1, w_rs2;
  logic       w_is_ld, w_is_st, w_is_nop, w_is_imm, w_is_rtype;
  logic       w_use_rs1, w_use_rs2;
  stage_t     w_dec;
  logic       w_stall;
  logic [1:0] w_sel_a, w_sel_b;

  assign w_opcode = bus.ins[19:15];
  assign w_rd     = bus.ins[14:10];
  assign w_rs1    = bus.ins[9:5];
  assign w_rs2    = bus.ins[4:0];

  assign w_is_ld    = (w_opcode == OP_LD);
  assign w_is_st    = (w_opcode == OP_ST);
  assign w_is_nop   = (w_opcode == OP_NOP);
  assign w_is_imm   = w_opcode[4] & ~w_is_nop;
  assign w_is_rtype = ~w_is_imm & ~w_is_nop & ~w_is_ld & ~w_is_st;

  // Inactive source fields never forward or stall, whatever their bit pattern.
  assign w_use_rs1 = ~w_is_nop;
  assign w_use_rs2 = w_is_rtype | w_is_st;

  assign w_dec = '{valid: 1'b1, wr: ~w_is_st & ~w_is_nop, ld: w_is_ld, rd: w_rd};

  function automatic logic hit(input stage_t s, input logic [4:0] src);
    return s.valid & s.wr & (s.rd == src);
  endfunction

  // A matching load in EX yields 0 here; the stall path covers that case.
  function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t dm,
                                         input stage_t wb, input logic [4:0] src,
                                         input logic active);
    if (!active)          return 2'd0;
    if (hit(ex, src))     return ex.ld ? 2'd0 : 2'd1;
    if (hit(dm, src))     return 2'd2;
    if (hit(wb, src))     return 2'd3;
    return 2'd0;
  endfunction

  assign w_stall = bus.ins_valid & r_ex.valid & r_ex.ld &
                   ((w_use_rs1 & (r_ex.rd == w_rs1)) | (w_use_rs2 & (r_ex.rd == w_rs2)));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sel_a = 2'd0;
    w_sel_b = 2'd0;
    if (bus.ins_valid && !w_stall) begin
      w_sel_a = fwd_sel(r_ex, r_dm, r_wb, w_rs1, w_use_rs1);
      w_sel_b = fwd_sel(r_ex, r_dm, r_wb, w_rs2, w_use_rs2);
    end
  end

  // NOTE: state uses non-blocking assignments so all stages shift off the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex        <= BUBBLE;
      r_dm        <= BUBBLE;
      r_wb        <= BUBBLE;
      r_stall_cnt <= 8'd0;
    end else begin
      r_wb <= r_dm;
      r_dm <= r_ex;
      r_ex <= (bus.ins_valid && !w_stall) ? w_dec : BUBBLE;
      if (w_stall && (r_stall_cnt != 8'hFF))
        r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign bus.mux_sel_a = w_sel_a;
  assign bus.mux_sel_b = w_sel_b;
  assign bus.imm_sel   = bus.ins_valid & w_is_imm;
  assign bus.stall     = w_stall;
  assign bus.RW_dm     = r_dm.rd;
  assign bus.RW_wb     = r_wb.rd;
  assign bus.wr_en_wb  = r_wb.valid & r_wb.wr;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl: stimulus queues hand-computed
// expectations, an independent monitor pops and compares them.
module tb_hazard_fwd_ctrl;

  localparam logic [4:0] ADD  = 5'h00;
  localparam logic [4:0] ADDI = 5'h10;
  localparam logic [4:0] LD   = 5'h08;
  localparam logic [4:0] ST   = 5'h09;
  localparam logic [4:0] NOP  = 5'h1F;
  localparam int X = -1;  // field not checked in this vector

  typedef struct {
    int    cyc;
    string name;
    int    sa, sb, im, st, cnt, rwd, rww, wwb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb_q[$];
  event sample_ev;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    if (exp < 0) return;
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  task automatic push(input string nm, input int sa, input int sb, input int im,
                      input int st, input int cnt, input int rwd, input int rww,
                      input int wwb);
    exp_t e;
    e.cyc = cyc; e.name = nm;
    e.sa = sa; e.sb = sb; e.im = im; e.st = st;
    e.cnt = cnt; e.rwd = rwd; e.rww = rww; e.wwb = wwb;
    sb_q.push_back(e);
  endtask

  task automatic apply(input bit rst, input bit v, input logic [19:0] i, input string nm,
                       input int sa, input int sb, input int im, input int st,
                       input int cnt, input int rwd, input int rww, input int wwb);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.ins       = i;
    bus.ins_valid = v;
    push(nm, sa, sb, im, st, cnt, rwd, rww, wwb);
  endtask

  // Monitor: compares every queued expectation whose cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc) begin
          n_vec++;
          n_miss++;
          $display("FAIL %s.stale: sampled in cycle %0d, expected cycle %0d", e.name, cyc, e.cyc);
        end else begin
          chk(e.name, "mux_sel_a", int'(bus.mux_sel_a), e.sa);
          chk(e.name, "mux_sel_b", int'(bus.mux_sel_b), e.sb);
          chk(e.name, "imm_sel",   int'(bus.imm_sel),   e.im);
          chk(e.name, "stall",     int'(bus.stall),     e.st);
          chk(e.name, "stall_cnt", int'(bus.stall_cnt), e.cnt);
          chk(e.name, "RW_dm",     int'(bus.RW_dm),     e.rwd);
          chk(e.name, "RW_wb",     int'(bus.RW_wb),     e.rww);
          chk(e.name, "wr_en_wb",  int'(bus.wr_en_wb),  e.wwb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] c_ins;
    int          k;
    reset         = 1'b1;
    bus.ins       = '0;
    bus.ins_valid = 1'b0;

    //    rst v  ins                         name          sa sb im st cnt rwd rww wwb
    apply(1, 0, '0,                          "reset",      0, 0, 0, 0, 0,  0,  0,  0);
    apply(0, 1, enc(ADD, 5, 1, 2),           "add_r5",     0, 0, 0, 0, 0,  X,  X,  0);
    apply(0, 1, enc(ADD, 6, 5, 5),           "b2b_ex",     1, 1, 0, 0, 0,  X,  X,  0);
    apply(0, 1, enc(ADDI, 9, 1, 6),          "imm_rs2",    0, 0, 1, 0, 0,  5,  X,  0);
    apply(0, 0, '0,                          "bubble1",    0, 0, 0, 0, 0,  6,  5,  1);
    apply(0, 1, enc(LD, 7, 2, 0),            "ld_r7",      0, 0, 0, 0, 0,  9,  6,  1);
    apply(0, 1, enc(ADD, 8, 7, 3),           "lu_stall",   0, 0, 0, 1, 0,  X,  9,  1);
    apply(0, 1, enc(ADD, 8, 7, 3),           "lu_fwd_dm",  2, 0, 0, 0, 1,  7,  X,  0);
    apply(0, 0, '0,                          "bubble2",    0, 0, 0, 0, 1,  X,  7,  1);
    apply(0, 1, enc(ADD, 4, 0, 0),           "prod_a_r4",  0, 0, 0, 0, 1,  8,  X,  0);
    apply(0, 1, enc(ADD, 10, 1, 1),          "mid_r10",    0, 0, 0, 0, 1,  X,  8,  1);
    apply(0, 1, enc(ADD, 4, 2, 2),           "prod_b_r4",  0, 0, 0, 0, 1,  4,  X,  0);
    apply(0, 1, enc(ADD, 11, 4, 3),          "prio_ex",    1, 0, 0, 0, 1,  10, 4,  1);
    apply(0, 1, enc(ADD, 11, 4, 3),          "prio_dm",    2, 0, 0, 0, 1,  4,  10, 1);
    apply(0, 1, enc(ADD, 11, 4, 3),          "prio_wb",    3, 0, 0, 0, 1,  11, 4,  1);
    apply(0, 1, enc(ADD, 11, 4, 3),          "prio_rf",    0, 0, 0, 0, 1,  11, 11, 1);
    apply(0, 1, enc(ADD, 0, 1, 2),           "write_r0",   0, 0, 0, 0, 1,  11, 11, 1);
    apply(0, 1, enc(ADD, 12, 3, 0),          "r0_fwd_ex",  0, 1, 0, 0, 1,  11, 11, 1);
    apply(0, 1, enc(ST, 0, 5, 12),           "st_rs2",     0, 1, 0, 0, 1,  0,  11, 1);
    apply(0, 1, enc(ADD, 13, 0, 0),          "st_no_wr",   3, 3, 0, 0, 1,  12, 0,  1);
    apply(0, 1, enc(NOP, 0, 13, 13),         "nop_src",    0, 0, 0, 0, 1,  0,  12, 1);
    apply(0, 0, '0,                          "st_wb",      0, 0, 0, 0, 1,  13, 0,  0);
    apply(0, 1, enc(LD, 14, 1, 0),           "ld_r14",     0, 0, 0, 0, 1,  0,  13, 1);
    apply(0, 1, enc(ADD, 15, 14, 14),        "stall_pre",  0, 0, 0, 1, 1,  X,  0,  0);

    // Reset in the middle of the stall cycle must drop stall immediately.
    @(negedge clk);
    #2;
    reset = 1'b1;
    push("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    ->sample_ev;

    apply(0, 0, '0,                          "post_rst1",  0, 0, 0, 0, 0,  0,  0,  0);
    apply(0, 0, '0,                          "post_rst2",  0, 0, 0, 0, 0,  0,  0,  0);
    apply(0, 0, '0,                          "post_rst3",  0, 0, 0, 0, 0,  0,  0,  0);

    // 260 load-use pairs drive stall_cnt into saturation.
    c_ins = enc(ADD, 3, 1, 1);
    for (int i = 0; i < 260; i++) begin
      k = (i < 255) ? i : 255;
      apply(0, 1, enc(LD, 1, 2, 0), "sat_ld",    0, 0, 0, 0, k, X, X, X);
      apply(0, 1, c_ins,            "sat_stall", 0, 0, 0, 1, k, X, X, X);
      k = (i + 1 < 255) ? i + 1 : 255;
      apply(0, 1, c_ins,            "sat_fwd",   2, 2, 0, 0, k, 1, X, X);
    end
    apply(0, 0, '0,                          "sat_hold",   0, 0, 0, 0, 255, X, X, X);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
